// File: rtl/adder_pkg.sv
// Shared definitions for the byte adder and its accumulator stage.
// The accumulator FSM states and the operand widths live here so that the
// adder and the accumulator agree on them.
package adder_pkg;

    localparam int BYTE_W    = 8;
    localparam int OPERAND_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_acc_ctrl.sv
// Burst controller for adder_accumulator: three-state FSM (IDLE/ACCUM/HOLD)
// plus the beat counter. It produces the handshake signals and the clear /
// load strobes that steer the datapath in the top module.
module adder_acc_ctrl
    import adder_pkg::*;
#(
    parameter int N_OPERANDS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic busy,
    output logic clear,
    output logic load_en,
    output logic last_beat
);

    localparam int CNT_W = $clog2(N_OPERANDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_OPERANDS - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] count_reg;

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Beat counter: restarts with every new burst, counts accepted beats.
    // It stops at N_OPERANDS because the FSM leaves ACCUM on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load_en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        clear      = 1'b0;
        load_en    = 1'b0;
        last_beat  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_en = 1'b1;
                    if (count_reg == LAST_IDX) begin
                        last_beat  = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // A start on the handshake cycle chains straight into
                    // the next burst without an idle cycle.
                    if (start) begin
                        clear      = 1'b1;
                        state_next = ST_ACCUM;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_reg != ST_IDLE);

endmodule

// File: rtl/adder_accumulator.sv
// Accumulates bursts of N_OPERANDS 9-bit adder results ({carry, sum}) into
// an ACC_WIDTH running total and presents it through a valid/ready output.
// Optional feature macro: ADDER_ACC_SATURATE_EN -- when defined the total
// saturates at all-ones on overflow instead of wrapping.
module adder_accumulator
    import adder_pkg::*;
#(
    parameter int ACC_WIDTH  = 16,
    parameter int N_OPERANDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BYTE_W-1:0]    in_sum,
    input  logic                 in_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_total,
    output logic                 out_overflow,
    output logic                 busy
);

    logic                 clear;
    logic                 load_en;
    logic                 last_beat;
    logic [ACC_WIDTH:0]   operand;
    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 ovf_reg;
    logic                 ovf_next;
    logic [ACC_WIDTH-1:0] total_reg;
    logic                 total_ovf_reg;

    adder_acc_ctrl #(
        .N_OPERANDS (N_OPERANDS)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .busy      (busy),
        .clear     (clear),
        .load_en   (load_en),
        .last_beat (last_beat)
    );

    // The carry is bit 8 of the operand; the sum is one bit wider than the
    // accumulator so its top bit is this beat's overflow.
    assign operand  = {{(ACC_WIDTH + 1 - OPERAND_W){1'b0}}, in_carry, in_sum};
    assign sum_wide = {1'b0, acc_reg} + operand;

    // Next accumulator value: wrap by default, pin at all-ones when saturating.
    always_comb begin
        acc_next = sum_wide[ACC_WIDTH-1:0];
        ovf_next = ovf_reg | sum_wide[ACC_WIDTH];
`ifdef ADDER_ACC_SATURATE_EN
        if (ovf_next) begin
            acc_next = '1;
        end
`endif
    end

    // Running total and sticky overflow, cleared at the start of each burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (clear) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (load_en) begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
        end
    end

    // Output register: captured with the last beat so it is visible the same
    // edge HOLD is entered, and zeroed once the total has been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_reg     <= '0;
            total_ovf_reg <= 1'b0;
        end else if (last_beat) begin
            total_reg     <= acc_next;
            total_ovf_reg <= ovf_next;
        end else if (out_valid && out_ready) begin
            total_reg     <= '0;
            total_ovf_reg <= 1'b0;
        end
    end

    assign out_total    = total_reg;
    assign out_overflow = total_ovf_reg;

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench for adder_accumulator. Two instances share all inputs:
// dut_a with ACC_WIDTH=16 and dut_b with ACC_WIDTH=9 (overflow coverage).
// Expected burst totals are pushed to a scoreboard as beats are driven and
// popped when the output is taken.
module tb_adder_accumulator;

    localparam int N_OPS = 4;
    localparam int W_A   = 16;
    localparam int W_B   = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic [7:0]     in_sum = 8'h00;
    logic           in_carry = 1'b0;
    logic           out_ready = 1'b0;

    logic           a_in_ready, a_out_valid, a_out_overflow, a_busy;
    logic [W_A-1:0] a_out_total;
    logic           b_in_ready, b_out_valid, b_out_overflow, b_busy;
    logic [W_B-1:0] b_out_total;

    typedef struct {
        int unsigned tot_a;
        bit          ovf_a;
        int unsigned tot_b;
        bit          ovf_b;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned burst_sum = 0;

    always #5 clk = ~clk;

    adder_accumulator #(.ACC_WIDTH(W_A), .N_OPERANDS(N_OPS)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_total(a_out_total), .out_overflow(a_out_overflow), .busy(a_busy)
    );

    adder_accumulator #(.ACC_WIDTH(W_B), .N_OPERANDS(N_OPS)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_total(b_out_total), .out_overflow(b_out_overflow), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of one burst total for a given accumulator width.
    function automatic int unsigned model_total(input int unsigned sum, input int w);
        int unsigned lim = 32'd1 << w;
`ifdef ADDER_ACC_SATURATE_EN
        return (sum >= lim) ? lim - 1 : sum;
`else
        return sum % lim;
`endif
    endfunction

    function automatic bit model_ovf(input int unsigned sum, input int w);
        return sum >= (32'd1 << w);
    endfunction

    task automatic push_expected();
        exp_t e;
        e.tot_a = model_total(burst_sum, W_A);
        e.ovf_a = model_ovf(burst_sum, W_A);
        e.tot_b = model_total(burst_sum, W_B);
        e.ovf_b = model_ovf(burst_sum, W_B);
        sb.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a_in_ready"},  a_in_ready, 0);
        check({tag, "_a_out_valid"}, a_out_valid, 0);
        check({tag, "_a_total"},     a_out_total, 0);
        check({tag, "_a_ovf"},       a_out_overflow, 0);
        check({tag, "_a_busy"},      a_busy, 0);
        check({tag, "_b_total"},     b_out_total, 0);
        check({tag, "_b_busy"},      b_busy, 0);
    endtask

    task automatic begin_burst();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        burst_sum = 0;
        check("start_in_ready", a_in_ready, 1);
    endtask

    // One beat, preceded by an optional random gap; in_ready is high in ACCUM.
    task automatic send_beat(input logic [8:0] op, input bit last);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        {in_carry, in_sum} = op;
        check("beat_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        burst_sum = burst_sum + op;
        if (last) begin
            push_expected();
            check("latency_a_valid", a_out_valid, 1);
            check("latency_b_valid", b_out_valid, 1);
        end else begin
            check("mid_a_valid", a_out_valid, 0);
        end
    endtask

    task automatic send_burst_const(input logic [8:0] op);
        for (int i = 0; i < N_OPS; i++) send_beat(op, i == N_OPS - 1);
    endtask

    // Pop the scoreboard and compare against what both DUTs present now.
    task automatic compare_out();
        exp_t e;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("a_total", a_out_total, e.tot_a);
            check("a_ovf",   a_out_overflow, e.ovf_a);
            check("b_total", b_out_total, e.tot_b);
            check("b_ovf",   b_out_overflow, e.ovf_b);
            $display("burst sum=%0h a=%0h/%0b b=%0h/%0b", burst_sum,
                     a_out_total, a_out_overflow, b_out_total, b_out_overflow);
        end
    endtask

    task automatic collect();
        int cyc = 0;
        while (!a_out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid_timeout", a_out_valid, 1);
        @(negedge clk);
        compare_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_valid", a_out_valid, 0);
        check("post_hs_busy",  a_busy, 0);
        check("post_hs_total", a_out_total, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Reset mid-burst after two beats: outputs drop at once
        begin_burst();
        send_beat(9'h0FF, 1'b0);
        send_beat(9'h0FF, 1'b0);
        @(negedge clk);
        check("pre_rst_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // in_valid in IDLE is ignored
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_busy", a_busy, 0);

        // Basic burst -> 0x136, also proves the partial total was discarded
        begin_burst();
        send_beat(9'h000, 1'b0);
        send_beat(9'h004, 1'b0);
        send_beat(9'h032, 1'b0);
        send_beat(9'h100, 1'b1);
        collect();

        // Overflow burst with the output stalled for 5 cycles
        begin_burst();
        send_burst_const(9'h1FF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sum   = 8'hAA;
            check("stall_in_ready", a_in_ready, 0);
            check("stall_valid",    a_out_valid, 1);
            check("stall_a_total",  a_out_total, sb[0].tot_a);
            check("stall_b_total",  b_out_total, sb[0].tot_b);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Back-to-back: start together with the handshake
        compare_out();
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start     = 1'b0;
        burst_sum = 0;
        check("b2b_in_ready", a_in_ready, 1);
        check("b2b_busy",     a_busy, 1);
        check("b2b_valid",    a_out_valid, 0);
        check("b2b_total",    a_out_total, 0);
        send_burst_const(9'h0FF);
        collect();

        // A few random bursts
        for (int b = 0; b < 4; b++) begin
            begin_burst();
            for (int i = 0; i < N_OPS; i++)
                send_beat(9'($urandom_range(0, 511)), i == N_OPS - 1);
            collect();
        end

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
